// File: rtl/mmcm_reset_supervisor.sv
// MMCM reset and lock supervisor on the free-running reference clock.
// Pulses the MMCM reset, waits for a synchronised lock, and retries after a
// timeout. The system reset is released only after lock has been stable for
// a full window. Retry and lock-loss counts are kept for board diagnostics.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_RST_MMCM  | mmcm_rst held high for RST_PULSE_CYCLES
// ST_WAIT_LOCK | MMCM released, waiting for lock, retry after the timeout
// ST_STABILIZE | lock seen, must hold for STABLE_CYCLES before release
// ST_RUN       | sys_rst released, any lock drop restarts the MMCM
module mmcm_reset_supervisor #(
   parameter int TCQ                 = 1,
   parameter int LOCK_SYNC_STAGES    = 3,
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 100000,
   parameter int STABLE_CYCLES       = 1024
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       locked_in,
   input  logic       clear_cnt,
   output logic       mmcm_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic [7:0] retry_cnt,
   output logic [7:0] lock_loss_cnt
);

   localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                            RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   // The shared timer is a down-counter: it is loaded with the phase length
   // minus one on every state change and the phase ends at terminal count 0.
   localparam logic [CNT_W-1:0] RST_TC     = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_TC  = CNT_W'(STABLE_CYCLES - 1);

   // Refuse to elaborate with parameter values the sequencing cannot honour.
   if (LOCK_SYNC_STAGES < 2 || RST_PULSE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 ||
       STABLE_CYCLES < 1 || TCQ < 0) begin : g_bad_params
      $error("mmcm_reset_supervisor: parameter out of range");
   end

   typedef enum logic [1:0] {
      ST_RST_MMCM  = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABILIZE = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   state_t                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [LOCK_SYNC_STAGES-1:0] sync_q, sync_d;
   logic                        mmcm_rst_q, mmcm_rst_d;
   logic                        sys_rst_q, sys_rst_d;
   logic                        ready_q, ready_d;
   logic [7:0]                  retry_q, retry_d;
   logic [7:0]                  loss_q, loss_d;
   logic                        lock_s;
   logic                        retry_inc;
   logic                        loss_inc;

   assign lock_s = sync_q[LOCK_SYNC_STAGES-1];

   // Shift the asynchronous lock flag through the synchroniser chain.
   always_comb begin
      sync_d = {sync_q[LOCK_SYNC_STAGES-2:0], locked_in};
   end

   // Next state, timer reload on every transition, counter increment requests.
   always_comb begin
      state_d   = state_q;
      cnt_d     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
      retry_inc = 1'b0;
      loss_inc  = 1'b0;
      case (state_q)
         ST_RST_MMCM: begin
            if (cnt_q == '0) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = TIMEOUT_TC;
            end
         end
         ST_WAIT_LOCK: begin
            // A lock arriving on the timeout cycle still wins.
            if (lock_s) begin
               state_d = ST_STABILIZE;
               cnt_d   = STABLE_TC;
            end else if (cnt_q == '0) begin
               state_d   = ST_RST_MMCM;
               cnt_d     = RST_TC;
               retry_inc = 1'b1;
            end
         end
         ST_STABILIZE: begin
            // A glitch is not a retry: go back and wait with a fresh timeout.
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = TIMEOUT_TC;
            end else if (cnt_q == '0) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            if (!lock_s) begin
               state_d  = ST_RST_MMCM;
               cnt_d    = RST_TC;
               loss_inc = 1'b1;
            end
         end
         default: begin
            state_d = ST_RST_MMCM;
            cnt_d   = RST_TC;
         end
      endcase
   end

   // Outputs are decoded from the next state so they switch on the same edge
   // as the transition and come straight from flops.
   always_comb begin
      mmcm_rst_d = (state_d == ST_RST_MMCM);
      sys_rst_d  = (state_d != ST_RUN);
      ready_d    = (state_d == ST_RUN);
   end

   // Saturating diagnostic counters; a clear beats a coincident increment.
   always_comb begin
      retry_d = retry_q;
      loss_d  = loss_q;
      if (clear_cnt) begin
         retry_d = '0;
         loss_d  = '0;
      end else begin
         if (retry_inc && (retry_q != 8'hFF)) begin
            retry_d = retry_q + 8'd1;
         end
         if (loss_inc && (loss_q != 8'hFF)) begin
            loss_d = loss_q + 8'd1;
         end
      end
   end

   // State, timer, synchroniser and output registers with async reset.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q    <= ST_RST_MMCM;
         cnt_q      <= RST_TC;
         sync_q     <= '0;
         mmcm_rst_q <= 1'b1;
         sys_rst_q  <= 1'b1;
         ready_q    <= 1'b0;
         retry_q    <= '0;
         loss_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sync_q     <= sync_d;
         mmcm_rst_q <= mmcm_rst_d;
         sys_rst_q  <= sys_rst_d;
         ready_q    <= ready_d;
         retry_q    <= retry_d;
         loss_q     <= loss_d;
      end
   end

   assign mmcm_rst      = mmcm_rst_q;
   assign sys_rst       = sys_rst_q;
   assign ready         = ready_q;
   assign retry_cnt     = retry_q;
   assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_mmcm_reset_supervisor.sv
// Bench for mmcm_reset_supervisor. Stimulus pushes the expected output
// vector and the edge number on which it must appear; the monitor pops an
// entry every time the sampled outputs change and compares both.
module tb_mmcm_reset_supervisor;

   logic       clk_in    = 1'b0;
   logic       reset     = 1'b0;
   logic       locked_in = 1'b0;
   logic       clear_cnt = 1'b0;
   logic       mmcm_rst;
   logic       sys_rst;
   logic       ready;
   logic [7:0] retry_cnt;
   logic [7:0] lock_loss_cnt;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   typedef struct {
      int          at;
      logic [18:0] val;
   } exp_t;

   exp_t exp_q[$];

   localparam logic [18:0] RST_VEC = {1'b1, 1'b1, 1'b0, 8'd0, 8'd0};

   mmcm_reset_supervisor #(
      .TCQ                 (1),
      .LOCK_SYNC_STAGES    (3),
      .RST_PULSE_CYCLES    (4),
      .LOCK_TIMEOUT_CYCLES (50),
      .STABLE_CYCLES       (8)
   ) dut (
      .clk_in        (clk_in),
      .reset         (reset),
      .locked_in     (locked_in),
      .clear_cnt     (clear_cnt),
      .mmcm_rst      (mmcm_rst),
      .sys_rst       (sys_rst),
      .ready         (ready),
      .retry_cnt     (retry_cnt),
      .lock_loss_cnt (lock_loss_cnt)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   function automatic logic [18:0] vec(input logic m, input logic s, input logic r,
                                       input int rc, input int lc);
      return {m, s, r, rc[7:0], lc[7:0]};
   endfunction

   function automatic logic [18:0] outs();
      return {mmcm_rst, sys_rst, ready, retry_cnt, lock_loss_cnt};
   endfunction

   task automatic push(input int at, input logic [18:0] v);
      exp_t e;
      e.at  = at;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk_in);
   endtask

   // Monitor: every output change is matched against the next expectation.
   initial begin
      logic [18:0] prev;
      logic [18:0] obs;
      exp_t        e;
      prev = RST_VEC;
      forever begin
         @(negedge clk_in);
         obs = outs();
         if (obs !== prev) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_change cyc=%0d got=%h (m,s,r,retry,loss)", cyc, obs);
            end else begin
               e = exp_q.pop_front();
               if (e.at != cyc || e.val !== obs) begin
                  bad++;
                  $display("FAIL output_event got cyc=%0d val=%h want cyc=%0d val=%h",
                           cyc, obs, e.at, e.val);
               end
            end
            prev = obs;
         end
      end
   end

   // Stimulus: directed scenarios with hand-computed edge numbers.
   initial begin
      int c0, c1, c2, c3, c4, c5, c6, c7, c8, base, rc, lc;

      #1 reset = 1'b1;
      #1;
      total++;
      if (outs() !== RST_VEC) begin
         bad++;
         $display("FAIL reset_state got=%h want=%h", outs(), RST_VEC);
      end

      // Nominal start: 4-edge MMCM pulse, lock 10 cycles later, 4+8 edges to RUN.
      wait_cyc(3);
      c0 = cyc;
      reset = 1'b0;
      push(c0 + 4, vec(0, 1, 0, 0, 0));
      wait_cyc(c0 + 10);
      c1 = cyc;
      locked_in = 1'b1;
      push(c1 + 12, vec(0, 0, 1, 0, 0));

      // Lock loss in RUN, then a clean repeat of the start-up sequence.
      wait_cyc(c1 + 20);
      c2 = cyc;
      locked_in = 1'b0;
      push(c2 + 4, vec(1, 1, 0, 0, 1));
      push(c2 + 8, vec(0, 1, 0, 0, 1));
      wait_cyc(c2 + 12);
      c3 = cyc;
      locked_in = 1'b1;
      push(c3 + 12, vec(0, 0, 1, 0, 1));

      // Another loss, then a 2-cycle lock glitch at STABILIZE cycle 5: the
      // glitch reaches lock_s exactly on the last window edge, so release is
      // pushed out by a full re-lock plus a fresh 8-cycle window.
      wait_cyc(c3 + 16);
      c4 = cyc;
      locked_in = 1'b0;
      push(c4 + 4, vec(1, 1, 0, 0, 2));
      push(c4 + 8, vec(0, 1, 0, 0, 2));
      wait_cyc(c4 + 12);
      c5 = cyc;
      locked_in = 1'b1;
      wait_cyc(c5 + 8);
      locked_in = 1'b0;
      wait_cyc(c5 + 10);
      locked_in = 1'b1;
      push(c5 + 22, vec(0, 0, 1, 0, 2));

      // No lock: retries every 54 cycles, saturation at 255, clear on a timeout edge.
      wait_cyc(c5 + 26);
      c6 = cyc;
      locked_in = 1'b0;
      push(c6 + 4, vec(1, 1, 0, 0, 3));
      push(c6 + 8, vec(0, 1, 0, 0, 3));
      base = c6 + 8;
      for (int k = 1; k <= 302; k++) begin
         if (k <= 300) begin
            rc = (k > 255) ? 255 : k;
            lc = 3;
         end else begin
            rc = k - 301;
            lc = 0;
         end
         push(base + 54 * (k - 1) + 50, vec(1, 1, 0, rc, lc));
         push(base + 54 * k, vec(0, 1, 0, rc, lc));
      end
      wait_cyc(base + 54 * 300 + 49);
      clear_cnt = 1'b1;
      wait_cyc(base + 54 * 300 + 50);
      clear_cnt = 1'b0;

      // Async reset in the middle of STABILIZE, then a full restart.
      wait_cyc(base + 54 * 302 + 2);
      c7 = cyc;
      locked_in = 1'b1;
      wait_cyc(c7 + 7);
      push(c7 + 8, RST_VEC);
      #2 reset = 1'b1;
      #1;
      total++;
      if (outs() !== RST_VEC) begin
         bad++;
         $display("FAIL async_reset got=%h want=%h", outs(), RST_VEC);
      end
      wait_cyc(c7 + 10);
      c8 = cyc;
      reset = 1'b0;
      push(c8 + 4, vec(0, 1, 0, 0, 0));
      push(c8 + 13, vec(0, 0, 1, 0, 0));

      wait_cyc(c8 + 24);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL events_pending got=%0d want=0 next_cyc=%0d", exp_q.size(), exp_q[0].at);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmcm_reset_supervisor.md
# mmcm_reset_supervisor

Reset and lock supervisor for the carrier's MMCM clock generator. It runs on the free-running 100 MHz reference clock. It drives the MMCM reset, watches the MMCM lock flag, and retries the MMCM if lock does not arrive in time. It releases a single system reset only after lock has been continuously stable, and it reports lock-loss and retry counts for board diagnostics.

## Interface
Parameters:
- `TCQ`, 1: simulation clock-to-out delay (ns) on registered assignments.
- `LOCK_SYNC_STAGES`, 3: flip-flop stages synchronising `locked_in`. Minimum 2.
- `RST_PULSE_CYCLES`, 16: `mmcm_rst` high time per attempt. Minimum 1.
- `LOCK_TIMEOUT_CYCLES`, 100000: cycles allowed in WAIT_LOCK before a retry (1 ms at 100 MHz).
- `STABLE_CYCLES`, 1024: consecutive synchronised-lock cycles required before reset release. Minimum 1.

Ports:
- `clk_in`, in, 1: free-running reference clock. This is the same clock that feeds the MMCM CLKIN1, never an MMCM output.
- `reset`, in, 1: asynchronous, active-high reset. It is asserted asynchronously and deasserted synchronously by the upstream reset bridge.
- `locked_in`, in, 1: MMCM LOCKED. Asynchronous to `clk_in`.
- `clear_cnt`, in, 1: synchronous, single-cycle clear of both counters.
- `mmcm_rst`, out, 1: to MMCM RST, active-high.
- `sys_rst`, out, 1: active-high system reset for downstream logic.
- `ready`, out, 1: clocks valid. Always the logical inverse of `sys_rst`.
- `retry_cnt`, out, 8: number of lock-timeout retries, saturating.
- `lock_loss_cnt`, out, 8: number of lock losses seen in RUN, saturating.

## Operation
- `locked_in` passes through a chain of `LOCK_SYNC_STAGES` flops, producing `lock_s`. The chain resets to 0.
- One shared cycle counter, `cnt`, is used. Its width is the `$clog2` of the largest of the three cycle parameters. It is cleared on every state change.
- All outputs are registered.
- Reset values:
  - state = RST_MMCM, `cnt` = 0, sync chain = 0.
  - `mmcm_rst` = 1, `sys_rst` = 1, `ready` = 0.
  - `retry_cnt` = 0, `lock_loss_cnt` = 0.
- States and transitions:
  - RST_MMCM: `mmcm_rst` = 1, `sys_rst` = 1. When `cnt` = `RST_PULSE_CYCLES`-1, go to WAIT_LOCK. `mmcm_rst` falls on that same edge.
  - WAIT_LOCK: `mmcm_rst` = 0, `sys_rst` = 1.
    - If `lock_s` = 1, go to STABILIZE.
    - Else, if `cnt` = `LOCK_TIMEOUT_CYCLES`-1, go to RST_MMCM and increment `retry_cnt`.
    - Lock takes priority over timeout in the same cycle.
  - STABILIZE: `sys_rst` = 1.
    - If `lock_s` = 0, go to WAIT_LOCK with the timeout restarted. No counter changes.
    - Else, if `cnt` = `STABLE_CYCLES`-1, go to RUN. `sys_rst` falls and `ready` rises on that edge.
  - RUN: `sys_rst` = 0, `ready` = 1. If `lock_s` = 0, go to RST_MMCM. On that edge `mmcm_rst` rises, `sys_rst` rises, and `lock_loss_cnt` increments.
- Counter rules:
  - Both counters saturate at 255 and never wrap.
  - `clear_cnt` zeroes both counters. When a clear and an increment land on the same edge, the clear wins.
- Asserting `reset` in any state returns all registers to their reset values immediately, without waiting for a clock edge.
- `locked_in` pulses shorter than one `clk_in` period may be missed. This is accepted.

## Timing
- Reset release to `mmcm_rst` low: `RST_PULSE_CYCLES` rising edges.
- `locked_in` rise to leaving WAIT_LOCK: `LOCK_SYNC_STAGES`+1 edges.
- Entering STABILIZE to `sys_rst` low: `STABLE_CYCLES` edges.
- Timeout retry period (locked_in stuck low): `RST_PULSE_CYCLES` + `LOCK_TIMEOUT_CYCLES` cycles per attempt.
- `locked_in` fall in RUN to `sys_rst` high: `LOCK_SYNC_STAGES`+1 edges. Downstream logic tolerates this window on a dying clock.
- A counter increment is visible on the edge of the corresponding state transition.

## Test plan
All scenarios use `LOCK_SYNC_STAGES`=3, `RST_PULSE_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=50, `STABLE_CYCLES`=8.
1. Nominal start: release `reset`, then raise `locked_in` 10 cycles later. Required: `mmcm_rst` high for exactly 4 edges, STABILIZE entered 4 edges after the `locked_in` rise, and `sys_rst` 1→0 with `ready` 0→1 8 edges after that. Both counters stay 0.
2. No lock: hold `locked_in` at 0. Required: `mmcm_rst` pulses 4 cycles high every 54 cycles, and `retry_cnt` reads 1, 2, 3 after the 1st, 2nd, and 3rd timeouts. `sys_rst` stays 1.
3. Glitch during STABILIZE: drop `locked_in` for 2 cycles at STABILIZE cycle 5. Required: return to WAIT_LOCK, `sys_rst` stays 1 throughout, and the full 8-cycle stable window restarts on re-lock. `retry_cnt` and `lock_loss_cnt` are unchanged.
4. Lock loss in RUN: drop `locked_in`. Required: 4 edges later `sys_rst`=1, `ready`=0, `mmcm_rst`=1, and `lock_loss_cnt`=1. Then the full sequence of scenario 1 repeats.
5. Saturation and clear: force 300 timeouts. Required: `retry_cnt` = 255. Then pulse `clear_cnt` on the same edge as a timeout. Required: `retry_cnt` = 0, and the next timeout gives 1.
6. Async reset mid-STABILIZE: assert `reset` between clock edges. Required: `mmcm_rst`=1, `sys_rst`=1, `ready`=0, and counters = 0 before the next edge. After release, the sequence restarts from RST_MMCM.
